// File: rtl/mmio_display_ctrl.sv
// MMIO block for buttons, switches and an 8-digit seven-segment display.
// Register reads are combinational; display outputs are registered and time-multiplexed.
module mmio_display_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_en,
  input  logic [3:0]  adr,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        L,
  input  logic        R,
  input  logic [15:0] SW,
  output logic [7:0]  AN,
  output logic        DP,
  output logic [6:0]  A2G
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [2:0]    l_sync, r_sync;
  logic [15:0]   sw_meta, sw_s;
  logic          l_pend, r_pend;
  logic [31:0]   ddata;
  logic [16:0]   dctrl;
  logic [2:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr, st_wr, l_rise, r_rise;
  logic          lit;
  logic [3:0]    nib;
  logic          adr_unused;

  assign adr_unused = ^adr[1:0];
  assign wr     = io_en & memwrite;
  assign st_wr  = wr & (adr[3:2] == 2'd0);
  // [1] is the synchronized level, [2] its previous value for edge detection
  assign l_rise = l_sync[1] & ~l_sync[2];
  assign r_rise = r_sync[1] & ~r_sync[2];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      l_sync  <= '0;
      r_sync  <= '0;
      sw_meta <= '0;
      sw_s    <= '0;
      l_pend  <= 1'b0;
      r_pend  <= 1'b0;
      ddata   <= '0;
      dctrl   <= 17'h000FF;
    end else begin
      l_sync  <= {l_sync[1:0], L};
      r_sync  <= {r_sync[1:0], R};
      sw_meta <= SW;
      sw_s    <= sw_meta;
      // a new edge overrides a simultaneous write-1-to-clear
      l_pend  <= (l_pend & ~(st_wr & writedata[1])) | l_rise;
      r_pend  <= (r_pend & ~(st_wr & writedata[0])) | r_rise;
      if (wr && adr[3:2] == 2'd2) ddata <= writedata;
      if (wr && adr[3:2] == 2'd3) dctrl <= writedata[16:0];
    end
  end

  always_comb begin
    readdata = 32'h0;
    if (io_en) begin
      case (adr[3:2])
        2'd0:    readdata = {30'h0, l_pend, r_pend};
        2'd1:    readdata = {16'h0, sw_s};
        2'd2:    readdata = ddata;
        default: readdata = {15'h0, dctrl};
      endcase
    end
  end

  always_comb begin
    cnt_n = cnt - CW'(1);
    idx_n = idx;
    if (cnt == '0) begin
      cnt_n = CNT_MAX;
      idx_n = idx + 3'd1;
    end
  end

  assign lit = dctrl[idx_n] & ~dctrl[16];
  assign nib = ddata[{idx_n, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      cnt <= CNT_MAX;
      AN  <= 8'hFF;
      A2G <= 7'h7F;
      DP  <= 1'b1;
    end else begin
      idx <= idx_n;
      cnt <= cnt_n;
      AN  <= lit ? ~(8'b1 << idx_n) : 8'hFF;
      A2G <= lit ? hex7(nib) : 7'h7F;
      DP  <= lit ? ~dctrl[8 + idx_n] : 1'b1;
    end
  end

endmodule
